// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter whose state register is a bank of JK flip-flops.
// Optional one-hot decode of the count is built only when JK_DECODE_EN is defined.
module jk_mod_counter #(
   parameter int unsigned W   = 4,
   parameter int unsigned MOD = 10
) (
   input  logic           clk,
   input  logic           R,
   input  logic           en,
   input  logic           up,
   input  logic           load,
   input  logic [W-1:0]   load_val,
   output logic [W-1:0]   count,
   output logic [W-1:0]   j,
   output logic [W-1:0]   k,
   output logic           tc,
   output logic           err,
   output logic [MOD-1:0] dec
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic [W-1:0] r_count;
   logic         r_err;
   logic [W-1:0] w_next;
   logic         w_illegal;
   logic         w_oob;
   logic         w_at_last;
   logic         w_at_zero;

   assign w_illegal = (32'(load_val) >= MOD);
   assign w_oob     = (32'(r_count) >= MOD);
   assign w_at_last = (r_count == LAST);
   assign w_at_zero = (r_count == '0);

   // Next-state selection: load beats count enable; out-of-range state recovers to 0.
   always_comb begin
      w_next = r_count;
      if (load) begin
         w_next = w_illegal ? '0 : load_val;
      end else if (en) begin
         if (w_oob)
            w_next = '0;
         else if (up)
            w_next = w_at_last ? '0 : r_count + W'(1);
         else
            w_next = w_at_zero ? LAST : r_count - W'(1);
      end
   end

   // JK excitation; forced quiet while reset is asserted.
   always_comb begin
      j = '0;
      k = '0;
      if (!R) begin
         j = ~r_count & w_next;
         k = r_count & ~w_next;
      end
   end

   assign tc = en & ~load & ((up & w_at_last) | (~up & w_at_zero));

   // JK bank: Q' = (J & ~Q) | (~K & Q).
   always_ff @(posedge clk) begin
      if (R) begin
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_count <= (j & ~r_count) | (~k & r_count);
         r_err   <= load & w_illegal;
      end
   end

   assign count = r_count;
   assign err   = r_err;

`ifdef JK_DECODE_EN
   for (genvar gi = 0; gi < MOD; gi++) begin : g_dec
      assign dec[gi] = (r_count == W'(gi));
   end
`else
   assign dec = '0;
`endif

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: directed scenarios plus a randomized
// run against an arithmetic reference model. Decode expectation follows JK_DECODE_EN.
module tb_jk_mod_counter;

   localparam int unsigned W   = 4;
   localparam int unsigned MOD = 10;

   logic           clk;
   logic           rst;
   logic           en;
   logic           up;
   logic           load;
   logic [W-1:0]   load_val;
   logic [W-1:0]   count;
   logic [W-1:0]   j;
   logic [W-1:0]   k;
   logic           tc;
   logic           err;
   logic [MOD-1:0] dec;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] m_count;
   logic         m_err;

   jk_mod_counter #(.W(W), .MOD(MOD)) dut (
      .clk      (clk),
      .R        (rst),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .j        (j),
      .k        (k),
      .tc       (tc),
      .err      (err),
      .dec      (dec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference next value from the counting rules, using modular arithmetic.
   function automatic logic [W-1:0] model_next(input logic [W-1:0] c, input logic r,
                                               input logic ld, input logic [W-1:0] lv,
                                               input logic e, input logic u);
      int ci;
      int n;
      ci = int'(c);
      if (r)       n = 0;
      else if (ld) n = (int'(lv) < int'(MOD)) ? int'(lv) : 0;
      else if (e)  n = u ? (ci + 1) % int'(MOD) : (ci + int'(MOD) - 1) % int'(MOD);
      else         n = ci;
      return W'(n);
   endfunction

   function automatic logic model_tc(input logic [W-1:0] c, input logic ld,
                                     input logic e, input logic u);
      return e && !ld && (u ? (int'(c) == int'(MOD) - 1) : (c == '0));
   endfunction

   function automatic logic [MOD-1:0] model_dec(input logic [W-1:0] c);
      logic [MOD-1:0] d;
      d = '0;
`ifdef JK_DECODE_EN
      d[c] = 1'b1;
`endif
      return d;
   endfunction

   // Advance one edge and move the model with it.
   task automatic tick();
      logic [W-1:0] n;
      n = model_next(m_count, rst, load, load_val, en, up);
      m_err = !rst && load && (int'(load_val) >= int'(MOD));
      @(posedge clk);
      #1;
      m_count = n;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
      #1;
      n_tests++;
      if ((j !== '0) || (k !== '0)) begin
         n_fail++;
         $display("FAIL reset_jk_quiet: j=%b k=%b, required 0/0", j, k);
      end
      tick();
      tick();
      rst = 1'b0; en = 1'b0;
      #1;
      n_tests++;
      if (count !== '0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d, required 0", count);
      end
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err: got %b, required 0", err);
      end
      n_tests++;
      if ((j !== '0) || (k !== '0)) begin
         n_fail++;
         $display("FAIL reset_hold_jk: j=%b k=%b, required 0/0", j, k);
      end
      n_tests++;
      if (dec !== model_dec('0)) begin
         n_fail++;
         $display("FAIL reset_dec: got %b, required %b", dec, model_dec('0));
      end
   endtask

   task automatic test_count_up();
      int seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      en = 1'b1; up = 1'b1; load = 1'b0;
      for (int i = 0; i < 12; i++) begin
         #1;
         n_tests++;
         if (tc !== (m_count == W'(9))) begin
            n_fail++;
            $display("FAIL up_tc at count %0d: got %b, required %b", m_count, tc, (m_count == W'(9)));
         end
         if (m_count == W'(9)) begin
            n_tests++;
            if ((j !== 4'b0000) || (k !== 4'b1001)) begin
               n_fail++;
               $display("FAIL up_wrap_jk: j=%b k=%b, required 0000/1001", j, k);
            end
         end
         tick();
         n_tests++;
         if (count !== W'(seq[i])) begin
            n_fail++;
            $display("FAIL up_count step %0d: got %0d, required %0d", i, count, seq[i]);
         end
      end
   endtask

   task automatic test_count_down();
      int seq [3] = '{9, 8, 7};
      rst = 1'b1; en = 1'b0;
      tick();
      rst = 1'b0; en = 1'b1; up = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if (tc !== (i == 0)) begin
            n_fail++;
            $display("FAIL down_tc step %0d: got %b, required %b", i, tc, (i == 0));
         end
         tick();
         n_tests++;
         if (count !== W'(seq[i])) begin
            n_fail++;
            $display("FAIL down_count step %0d: got %0d, required %0d", i, count, seq[i]);
         end
      end
   endtask

   task automatic test_load();
      en = 1'b0; load = 1'b1; load_val = W'(5);
      tick();
      en = 1'b1; up = 1'b1; load_val = W'(7);
      #1;
      n_tests++;
      if (tc !== 1'b0) begin
         n_fail++;
         $display("FAIL load_tc_suppressed: got %b, required 0", tc);
      end
      tick();
      n_tests++;
      if ((count !== W'(7)) || (err !== 1'b0)) begin
         n_fail++;
         $display("FAIL load_legal: count=%0d err=%b, required 7/0", count, err);
      end
      load_val = W'(12);
      tick();
      n_tests++;
      if ((count !== '0) || (err !== 1'b1)) begin
         n_fail++;
         $display("FAIL load_illegal: count=%0d err=%b, required 0/1", count, err);
      end
      load = 1'b0; en = 1'b0;
      tick();
      n_tests++;
      if ((err !== 1'b0) || (count !== '0)) begin
         n_fail++;
         $display("FAIL load_err_clear: count=%0d err=%b, required 0/0", count, err);
      end
   endtask

   task automatic test_reset_mid();
      load = 1'b1; load_val = W'(6); en = 1'b0;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1; rst = 1'b1;
      #1;
      n_tests++;
      if ((j !== '0) || (k !== '0)) begin
         n_fail++;
         $display("FAIL mid_reset_jk: j=%b k=%b, required 0/0", j, k);
      end
      tick();
      n_tests++;
      if (count !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_count: got %0d, required 0", count);
      end
      rst = 1'b0;
      tick();
      n_tests++;
      if (count !== W'(1)) begin
         n_fail++;
         $display("FAIL mid_reset_resume: got %0d, required 1", count);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] n;
      logic [W-1:0] ej;
      logic [W-1:0] ek;
      logic [W-1:0] jk_q;
      for (int i = 0; i < 1000; i++) begin
         rst      = ($urandom_range(0, 39) == 0);
         en       = 1'($urandom_range(0, 3) != 0);
         up       = 1'($urandom);
         load     = ($urandom_range(0, 7) == 0);
         load_val = W'($urandom_range(0, 15));
         #1;
         n  = model_next(m_count, rst, load, load_val, en, up);
         ej = rst ? '0 : (~m_count & n);
         ek = rst ? '0 : (m_count & ~n);
         n_tests++;
         if (tc !== model_tc(m_count, load, en, up)) begin
            n_fail++;
            $display("FAIL rnd_tc cyc %0d: got %b, required %b", i, tc, model_tc(m_count, load, en, up));
         end
         n_tests++;
         if ((j & k) !== '0) begin
            n_fail++;
            $display("FAIL rnd_jk_overlap cyc %0d: j=%b k=%b, required j&k=0", i, j, k);
         end
         n_tests++;
         if ((j !== ej) || (k !== ek)) begin
            n_fail++;
            $display("FAIL rnd_jk cyc %0d: j=%b k=%b, required %b/%b", i, j, k, ej, ek);
         end
         if (!rst) begin
            jk_q = (j & ~count) | (~k & count);
            n_tests++;
            if (jk_q !== n) begin
               n_fail++;
               $display("FAIL rnd_jk_rule cyc %0d: JK gives %0d, required %0d", i, jk_q, n);
            end
         end
         n_tests++;
         if (dec !== model_dec(m_count)) begin
            n_fail++;
            $display("FAIL rnd_dec cyc %0d: got %b, required %b", i, dec, model_dec(m_count));
         end
         tick();
         n_tests++;
         if ((count !== m_count) || (err !== m_err)) begin
            n_fail++;
            $display("FAIL rnd_state cyc %0d: count=%0d err=%b, required %0d/%b", i, count, err, m_count, m_err);
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
      m_count = '0;
      m_err   = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
